simple_bus_arb_mem: RTL and testbench

Parametrised multi-master memory slave for the simple_bus protocol (req/gnt, start, mode, addr, data, rdy). It arbitrates NMASTERS requesters round-robin, owns a DEPTH-word on-chip memory, and serves single or fixed-length burst reads and writes. It replaces the single-client slave behind the bus and sits between the CPU-side masters and storage.

---
 rtl/simple_bus_arb_mem.sv | 186 ++++++++++++++++++
 tb/tb_simple_bus_arb_mem.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/simple_bus_arb_mem.sv
// Round-robin multi-master simple_bus slave with on-chip memory.
// Serves single and fixed-length burst reads/writes; out-of-range beats raise err.
module simple_bus_arb_mem #(
    parameter int NMASTERS  = 2,
    parameter int AWIDTH    = 8,
    parameter int DWIDTH    = 8,
    parameter int DEPTH     = 256,
    parameter int BURST_LEN = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NMASTERS-1:0]          req,
    input  logic [NMASTERS-1:0]          start,
    input  logic [2*NMASTERS-1:0]        mode,
    input  logic [NMASTERS*AWIDTH-1:0]   addr,
    input  logic [NMASTERS*DWIDTH-1:0]   wdata,
    output logic [NMASTERS-1:0]          gnt,
    output logic [NMASTERS-1:0]          rdy,
    output logic [DWIDTH-1:0]            rdata,
    output logic                         err
);

    localparam int PW = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;
    localparam int CW = $clog2(BURST_LEN + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANT   = 2'd1;
    localparam logic [1:0] S_ACCESS  = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [PW-1:0]       owner_q, owner_d;
    logic [NMASTERS-1:0] gnt_q, gnt_d;
    logic [NMASTERS-1:0] rdy_q, rdy_d;
    logic [DWIDTH-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                wr_q, wr_d;
    logic [AWIDTH-1:0]   baddr_q, baddr_d;
    logic [CW-1:0]       beats_q, beats_d;

    logic [DWIDTH-1:0]   mem_q [DEPTH];
    logic                mem_we;
    logic [AWIDTH-1:0]   mem_wa;
    logic [DWIDTH-1:0]   mem_wd;

    logic                found;
    logic [PW-1:0]       winner;
    int unsigned         rr_idx;

    logic                req_w, start_w;
    logic [1:0]          mode_w;
    logic [AWIDTH-1:0]   addr_w;
    logic [DWIDTH-1:0]   wdata_w;

    logic                in_range;
    logic [AWIDTH-1:0]   addr_next;

    // Search upward from ptr+1 so the last owner has lowest priority.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        rr_idx = 0;
        for (int unsigned k = 1; k <= NMASTERS; k++) begin
            rr_idx = (32'(ptr_q) + k) % NMASTERS;
            if (!found && req[rr_idx[PW-1:0]]) begin
                found  = 1'b1;
                winner = rr_idx[PW-1:0];
            end
        end
    end

    always_comb begin
        req_w   = 1'b0;
        start_w = 1'b0;
        mode_w  = '0;
        addr_w  = '0;
        wdata_w = '0;
        for (int unsigned i = 0; i < NMASTERS; i++) begin
            if (owner_q == PW'(i)) begin
                req_w   = req[i];
                start_w = start[i];
                mode_w  = mode[2*i +: 2];
                addr_w  = addr[AWIDTH*i +: AWIDTH];
                wdata_w = wdata[DWIDTH*i +: DWIDTH];
            end
        end
    end

    assign in_range  = 32'(baddr_q) < DEPTH;
    assign addr_next = AWIDTH'((32'(baddr_q) + 32'd1) % DEPTH);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        gnt_d   = gnt_q;
        rdy_d   = '0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        wr_d    = wr_q;
        baddr_d = baddr_q;
        beats_d = beats_q;
        mem_we  = 1'b0;
        mem_wa  = baddr_q;
        mem_wd  = wdata_w;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d = S_GRANT;
                    owner_d = winner;
                    gnt_d   = NMASTERS'(1) << winner;
                end
            end
            S_GRANT: begin
                if (!req_w) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                end else if (start_w) begin
                    state_d = S_ACCESS;
                    wr_d    = mode_w[0];
                    baddr_d = addr_w;
                    beats_d = mode_w[1] ? CW'(BURST_LEN) : CW'(1);
                end
            end
            S_ACCESS: begin
                rdy_d = gnt_q;
                err_d = !in_range;
                if (wr_q) begin
                    mem_we = in_range;
                end else begin
                    rdata_d = in_range ? mem_q[baddr_q] : '0;
                end
                baddr_d = addr_next;
                beats_d = beats_q - CW'(1);
                if (beats_q == CW'(1)) begin
                    state_d = S_RELEASE;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                ptr_d   = owner_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= PW'(NMASTERS - 1);
            owner_q <= '0;
            gnt_q   <= '0;
            rdy_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
            baddr_q <= '0;
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            rdy_q   <= rdy_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            wr_q    <= wr_d;
            baddr_q <= baddr_d;
            beats_q <= beats_d;
        end
    end

    // Storage is deliberately not cleared by reset; a write coinciding with rst is dropped.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    assign gnt   = gnt_q;
    assign rdy   = rdy_q;
    assign rdata = rdata_q;
    assign err   = err_q;

endmodule

// File: tb/tb_simple_bus_arb_mem.sv
// Directed scoreboard bench for simple_bus_arb_mem: a DEPTH=256 and a DEPTH=200
// instance share the same stimulus; expected beats are queued and compared at rdy.
module tb_simple_bus_arb_mem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  req, start;
    logic [3:0]  mode;
    logic [15:0] addr, wdata;
    logic [1:0]  gnt_a, rdy_a, gnt_b, rdy_b;
    logic [7:0]  rdata_a, rdata_b;
    logic        err_a, err_b;

    simple_bus_arb_mem #(.NMASTERS(2), .AWIDTH(8), .DWIDTH(8), .DEPTH(256), .BURST_LEN(4)) u_dut_a (
        .clk(clk), .rst(rst), .req(req), .start(start), .mode(mode), .addr(addr), .wdata(wdata),
        .gnt(gnt_a), .rdy(rdy_a), .rdata(rdata_a), .err(err_a)
    );

    simple_bus_arb_mem #(.NMASTERS(2), .AWIDTH(8), .DWIDTH(8), .DEPTH(200), .BURST_LEN(4)) u_dut_b (
        .clk(clk), .rst(rst), .req(req), .start(start), .mode(mode), .addr(addr), .wdata(wdata),
        .gnt(gnt_b), .rdy(rdy_b), .rdata(rdata_b), .err(err_b)
    );

    typedef struct {
        logic [1:0] rdy;
        logic [7:0] rd_a;
        logic       err_a;
        logic [7:0] rd_b;
        bit         chk_rd_b;
        logic       err_b;
        bit         chk_b;
    } beat_t;

    beat_t      sb[$];
    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    logic [7:0] last_rd_a = 8'h00;
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered at a negedge where master m should already hold the grant.
    task automatic xfer(input int m, input bit wr, input bit burst, input logic [7:0] a,
                        input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                        input logic [7:0] d3, input bit chk_b);
        logic [7:0] d [4];
        logic [7:0] aa, ab;
        beat_t      e;
        int         n;
        d  = '{d0, d1, d2, d3};
        n  = burst ? 4 : 1;
        aa = a;
        ab = a;
        for (int k = 0; k < n; k++) begin
            e.rdy   = 2'(1 << m);
            e.chk_b = chk_b;
            e.err_a = 1'b0;
            e.err_b = (ab >= 200);
            if (wr) begin
                mem_a[aa]  = d[k];
                if (ab < 200) mem_b[ab] = d[k];
                e.rd_a     = last_rd_a;
                e.rd_b     = 8'h00;
                e.chk_rd_b = 1'b0;
            end else begin
                e.rd_a     = mem_a[aa];
                last_rd_a  = e.rd_a;
                e.rd_b     = (ab >= 200) ? 8'h00 : mem_b[ab];
                e.chk_rd_b = 1'b1;
            end
            sb.push_back(e);
            aa = aa + 8'd1;
            ab = 8'((int'(ab) + 1) % 200);
        end

        chk("gnt_before_start", 32'(gnt_a), 32'(1 << m));
        start           = '0;
        start[m]        = 1'b1;
        mode            = '1;
        mode[2*m +: 2]  = {burst, wr};
        addr            = 16'h7777;
        addr[8*m +: 8]  = a;
        wdata           = 16'hEEEE;
        wdata[8*m +: 8] = d[0];
        @(negedge clk);
        start = '0;
        chk("rdy_not_yet", 32'(rdy_a), 32'd0);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (k + 1 < n) wdata[8*m +: 8] = d[k+1];
            e = sb.pop_front();
            chk("beat_rdy", 32'(rdy_a), 32'(e.rdy));
            chk("beat_gnt", 32'(gnt_a), 32'(e.rdy));
            chk("beat_rdata", 32'(rdata_a), 32'(e.rd_a));
            chk("beat_err", 32'(err_a), 32'(e.err_a));
            if (e.chk_b) begin
                chk("d200_rdy", 32'(rdy_b), 32'(e.rdy));
                chk("d200_err", 32'(err_b), 32'(e.err_b));
                if (e.chk_rd_b) chk("d200_rdata", 32'(rdata_b), 32'(e.rd_b));
            end
        end
        @(negedge clk);
        chk("gnt_released", 32'(gnt_a), 32'd0);
        chk("rdy_idle", 32'(rdy_a), 32'd0);
        chk("err_idle", 32'(err_a), 32'd0);
    endtask

    initial begin
        rst = 1'b1; req = '0; start = '0; mode = '0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(gnt_a), 32'd0);
        chk("rst_rdy", 32'(rdy_a), 32'd0);
        chk("rst_rdata", 32'(rdata_a), 32'd0);
        chk("rst_err", 32'(err_a), 32'd0);
        chk("rst_d200_gnt", 32'(gnt_b), 32'd0);
        chk("rst_d200_rdata", 32'(rdata_b), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_no_gnt", 32'(gnt_a), 32'd0);

        // Single write then single read by master 0.
        req = 2'b01;
        @(negedge clk);
        xfer(0, 1'b1, 1'b0, 8'h05, 8'hA5, 8'h00, 8'h00, 8'h00, 1'b1);
        @(negedge clk);
        xfer(0, 1'b0, 1'b0, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);

        // Both masters requesting: grants alternate with one idle cycle between.
        req = 2'b11;
        @(negedge clk);
        xfer(1, 1'b1, 1'b0, 8'h10, 8'h11, 8'h00, 8'h00, 8'h00, 1'b1);
        @(negedge clk);
        xfer(0, 1'b1, 1'b0, 8'h20, 8'h22, 8'h00, 8'h00, 8'h00, 1'b1);
        @(negedge clk);
        xfer(1, 1'b0, 1'b0, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        @(negedge clk);
        xfer(0, 1'b0, 1'b0, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);

        // Burst across the top of a 256-word memory.
        req = 2'b01;
        @(negedge clk);
        xfer(0, 1'b1, 1'b1, 8'hFE, 8'h01, 8'h02, 8'h03, 8'h04, 1'b0);
        @(negedge clk);
        xfer(0, 1'b0, 1'b1, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        xfer(0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        xfer(0, 1'b0, 1'b0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);

        // Out-of-range accesses on the DEPTH=200 instance.
        @(negedge clk);
        xfer(0, 1'b1, 1'b0, 8'd10, 8'h5A, 8'h00, 8'h00, 8'h00, 1'b1);
        @(negedge clk);
        xfer(0, 1'b1, 1'b0, 8'd210, 8'hC3, 8'h00, 8'h00, 8'h00, 1'b1);
        @(negedge clk);
        xfer(0, 1'b0, 1'b0, 8'd210, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        @(negedge clk);
        xfer(0, 1'b0, 1'b0, 8'd10, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);

        // Master 1 aborts before start; the pointer must not advance.
        req = 2'b10;
        @(negedge clk);
        chk("m1_grant", 32'(gnt_a), 32'd2);
        req = 2'b00;
        @(negedge clk);
        chk("abort_gnt", 32'(gnt_a), 32'd0);
        chk("abort_rdy", 32'(rdy_a), 32'd0);
        req = 2'b11;
        @(negedge clk);
        xfer(1, 1'b0, 1'b0, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);

        // Reset during the second beat of a write burst.
        @(negedge clk);
        xfer(0, 1'b1, 1'b1, 8'h30, 8'hF0, 8'hF1, 8'hF2, 8'hF3, 1'b1);
        req = 2'b01;
        @(negedge clk);
        chk("rst_burst_gnt", 32'(gnt_a), 32'd1);
        start = 2'b01; mode = 4'b1111; addr = 16'h7730; wdata = 16'hEE81;
        mem_a[8'h30] = 8'h81;
        mem_b[8'h30] = 8'h81;
        @(negedge clk);
        start = '0;
        @(negedge clk);
        chk("rst_burst_beat1_rdy", 32'(rdy_a), 32'd1);
        wdata[7:0] = 8'h82;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_gnt", 32'(gnt_a), 32'd0);
        chk("midrst_rdy", 32'(rdy_a), 32'd0);
        chk("midrst_err", 32'(err_a), 32'd0);
        chk("midrst_rdata", 32'(rdata_a), 32'd0);
        chk("midrst_d200_gnt", 32'(gnt_b), 32'd0);
        rst = 1'b0;
        last_rd_a = 8'h00;
        @(negedge clk);
        xfer(0, 1'b0, 1'b1, 8'h30, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        req = 2'b00;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
